// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants for the FP issue unit and its register file.
//   - FC_* : FPU opcode encodings driven on fc
//   - NREG / REG_W / DATA_W : register file geometry
//   - tag_match : helper comparing an in-flight destination tag to a source
package fpu_pkg;

  localparam int NREG   = 32;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [2:0] FC_ADD  = 3'b000;
  localparam logic [2:0] FC_SUB  = 3'b001;
  localparam logic [2:0] FC_MUL  = 3'b010;
  localparam logic [2:0] FC_ITOF = 3'b011;
  localparam logic [2:0] FC_DIV  = 3'b100;
  localparam logic [2:0] FC_FTOI = 3'b101;
  localparam logic [2:0] FC_SQRT = 3'b110;

  // True when a valid in-flight tag names register r.
  function automatic logic tag_match(input logic             v,
                                     input logic [REG_W-1:0] n,
                                     input logic [REG_W-1:0] r);
    return v && (n == r);
  endfunction

endpackage

// File: rtl/fpu_regfile.sv
// fpu_regfile: 32 x 32-bit FP register file.
//   clk, clr          : clock, asynchronous active-high clear (all entries -> 0)
//   i_we/i_waddr/i_wdata : single synchronous write port
//   i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b : two combinational read ports
// No hardwired zero register; read ports return the stored value only, the
// write-through bypass lives in the issue unit's forwarding mux.
module fpu_regfile
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_W-1:0]  i_raddr_a,
  input  logic [REG_W-1:0]  i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/fpu_issue_unit.sv
// fpu_issue_unit: ID-stage companion of the pipelined FPU.
//   Owns the FP register file, forwards operands (E3 result, then write-back,
//   then register file), detects RAW hazards against E1/E2 producers, turns
//   hazard / invalid slots into bubbles and keeps two saturating counters.
// Ports:
//   clk, clr                     : clock, async active-high reset
//   dec_*                        : decoded FP instruction in ID
//   flush, ein1, st_ds           : E1 cancel, memory-stall enable, div/sqrt stall
//   e1n/e1w .. e3n/e3w, ed       : in-flight destination tags and E3 result
//   wd/wn/ww                     : write-back port
//   a, b, fc, wf, fd, ein2       : issue-side inputs of the FPU
//   stall_id                     : hold PC/IF/ID
//   cnt_stall, cnt_issue         : saturating performance counters
module fpu_issue_unit
  import fpu_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  logic              clk,
  input  logic              clr,
  input  logic              dec_valid,
  input  logic [2:0]        dec_fc,
  input  logic              dec_wf,
  input  logic [REG_W-1:0]  dec_fd,
  input  logic [REG_W-1:0]  dec_fs,
  input  logic [REG_W-1:0]  dec_ft,
  input  logic              dec_use_fs,
  input  logic              dec_use_ft,
  input  logic              flush,
  input  logic              ein1,
  input  logic              st_ds,
  input  logic [REG_W-1:0]  e1n,
  input  logic [REG_W-1:0]  e2n,
  input  logic [REG_W-1:0]  e3n,
  input  logic              e1w,
  input  logic              e2w,
  input  logic              e3w,
  input  logic [DATA_W-1:0] ed,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_W-1:0]  wn,
  input  logic              ww,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [2:0]        fc,
  output logic              wf,
  output logic [REG_W-1:0]  fd,
  output logic              ein2,
  output logic              stall_id,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_issue
);

  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic              w_raw_fs;
  logic              w_raw_ft;
  logic              w_raw;
  logic              w_bubble;
  logic              w_advance;
  logic [CNT_W-1:0]  r_cnt_stall;
  logic [CNT_W-1:0]  r_cnt_issue;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fpu_regfile u_regfile (
    .clk       (clk),
    .clr       (clr),
    .i_we      (ww),
    .i_waddr   (wn),
    .i_wdata   (wd),
    .i_raddr_a (dec_fs),
    .i_raddr_b (dec_ft),
    .o_rdata_a (w_rf_a),
    .o_rdata_b (w_rf_b)
  );

  // E3 is younger than the write-back slot, so it wins when both match.
  always_comb begin
    a = w_rf_a;
    if (tag_match(e3w, e3n, dec_fs))     a = ed;
    else if (tag_match(ww, wn, dec_fs))  a = wd;

    b = w_rf_b;
    if (tag_match(e3w, e3n, dec_ft))     b = ed;
    else if (tag_match(ww, wn, dec_ft))  b = wd;
  end

  // E1/E2 results are not yet available anywhere, so a match there stalls
  // regardless of any older E3/WB match on the same register.
  assign w_raw_fs = dec_use_fs &
                    (tag_match(e1w, e1n, dec_fs) | tag_match(e2w, e2n, dec_fs));
  assign w_raw_ft = dec_use_ft &
                    (tag_match(e1w, e1n, dec_ft) | tag_match(e2w, e2n, dec_ft));
  assign w_raw    = dec_valid & (w_raw_fs | w_raw_ft);

  assign stall_id = w_raw | st_ds | ~ein1;
  assign ein2     = ~flush;

  // Bubble forces fc to add so a held fdiv/fsqrt cannot re-launch its unit.
  assign w_bubble = w_raw | ~dec_valid;
  assign fc       = w_bubble ? FC_ADD : dec_fc;
  assign wf       = w_bubble ? 1'b0   : dec_wf;
  assign fd       = w_bubble ? '0     : dec_fd;

  // The pipeline only moves when neither the cache nor the divider holds it.
  assign w_advance = ein1 & ~st_ds;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt_stall <= '0;
      r_cnt_issue <= '0;
    end else begin
      if (w_advance && w_raw && (r_cnt_stall != '1))
        r_cnt_stall <= r_cnt_stall + CNT_ONE;
      if (w_advance && dec_valid && !w_raw && (r_cnt_issue != '1))
        r_cnt_issue <= r_cnt_issue + CNT_ONE;
    end
  end

  assign cnt_stall = r_cnt_stall;
  assign cnt_issue = r_cnt_issue;

endmodule

// File: tb/tb_fpu_issue_unit.sv
module tb_fpu_issue_unit;
  import fpu_pkg::*;

  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        dec_valid = 0;
  logic [2:0]  dec_fc = 0;
  logic        dec_wf = 0;
  logic [4:0]  dec_fd = 0, dec_fs = 0, dec_ft = 0;
  logic        dec_use_fs = 0, dec_use_ft = 0;
  logic        flush = 0, ein1 = 1, st_ds = 0;
  logic [4:0]  e1n = 0, e2n = 0, e3n = 0;
  logic        e1w = 0, e2w = 0, e3w = 0;
  logic [31:0] ed = 0, wd = 0;
  logic [4:0]  wn = 0;
  logic        ww = 0;
  logic [31:0] a, b;
  logic [2:0]  fc;
  logic        wf, ein2, stall_id;
  logic [4:0]  fd;
  logic [CNT_W-1:0] cnt_stall, cnt_issue;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 0;

  fpu_issue_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr),
    .dec_valid(dec_valid), .dec_fc(dec_fc), .dec_wf(dec_wf), .dec_fd(dec_fd),
    .dec_fs(dec_fs), .dec_ft(dec_ft), .dec_use_fs(dec_use_fs), .dec_use_ft(dec_use_ft),
    .flush(flush), .ein1(ein1), .st_ds(st_ds),
    .e1n(e1n), .e2n(e2n), .e3n(e3n), .e1w(e1w), .e2w(e2w), .e3w(e3w),
    .ed(ed), .wd(wd), .wn(wn), .ww(ww),
    .a(a), .b(b), .fc(fc), .wf(wf), .fd(fd), .ein2(ein2), .stall_id(stall_id),
    .cnt_stall(cnt_stall), .cnt_issue(cnt_issue)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int unsigned m_rf [32];
  int          m_cnt_stall = 0;
  int          m_cnt_issue = 0;

  function automatic bit in_flight(input logic [4:0] r);
    return (e1w && e1n == r) || (e2w && e2n == r);
  endfunction

  function automatic bit m_raw();
    return dec_valid && ((dec_use_fs && in_flight(dec_fs)) ||
                         (dec_use_ft && in_flight(dec_ft)));
  endfunction

  // Youngest visible value of register r: E3 result, then write-back, then file.
  function automatic logic [31:0] m_operand(input logic [4:0] r);
    if (e3w && e3n == r) return ed;
    if (ww && wn == r)   return wd;
    return m_rf[r];
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      foreach (m_rf[i]) m_rf[i] = 0;
      m_cnt_stall = 0;
      m_cnt_issue = 0;
    end else begin
      if (ein1 && !st_ds) begin
        if (m_raw()) m_cnt_stall = (m_cnt_stall < CNT_MAX) ? m_cnt_stall + 1 : CNT_MAX;
        else if (dec_valid) m_cnt_issue = (m_cnt_issue < CNT_MAX) ? m_cnt_issue + 1 : CNT_MAX;
      end
      if (ww) m_rf[wn] = wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      bit issue;
      issue = dec_valid && !m_raw();
      chk("a",         a,         m_operand(dec_fs));
      chk("b",         b,         m_operand(dec_ft));
      chk("fc",        {29'd0, fc}, issue ? {29'd0, dec_fc} : 32'd0);
      chk("wf",        {31'd0, wf}, issue ? {31'd0, dec_wf} : 32'd0);
      chk("fd",        {27'd0, fd}, issue ? {27'd0, dec_fd} : 32'd0);
      chk("ein2",      {31'd0, ein2}, {31'd0, !flush});
      chk("stall_id",  {31'd0, stall_id}, {31'd0, (m_raw() || st_ds || !ein1)});
      chk("cnt_stall", {16'd0, cnt_stall}, m_cnt_stall);
      chk("cnt_issue", {16'd0, cnt_issue}, m_cnt_issue);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  int saved_stall, saved_issue;

  initial begin
    tick(); tick();
    check_en = 1;
    clr = 0;
    settle();
    chk("rst_a", a, 32'h0);
    chk("rst_fc", {29'd0, fc}, 32'h0);
    chk("rst_wf", {31'd0, wf}, 32'h0);
    chk("rst_cnt", {16'd0, cnt_stall} | {16'd0, cnt_issue}, 32'h0);

    // write reg 3, read it back next cycle through the file
    tick();
    ww = 1; wn = 3; wd = 32'h3F800000; dec_fs = 3;
    settle();
    chk("wb_fwd_a", a, 32'h3F800000);
    tick();
    ww = 0;
    settle();
    chk("rf_a", a, 32'h3F800000);

    // reset mid-sequence clears the file immediately
    tick();
    clr = 1;
    settle();
    chk("clr_a", a, 32'h0);
    tick();
    clr = 0;

    // producer in E1 -> two stalls, then issue with ed forwarded
    dec_valid = 1; dec_fc = FC_ADD; dec_wf = 1; dec_fd = 9;
    dec_fs = 5; dec_use_fs = 1;
    e1w = 1; e1n = 5;
    settle();
    chk("e1_stall", {31'd0, stall_id}, 32'd1);
    chk("e1_wf", {31'd0, wf}, 32'd0);
    chk("e1_fd", {27'd0, fd}, 32'd0);
    tick();
    chk("e1_cnt_stall", {16'd0, cnt_stall}, 32'd1);
    e1w = 0; e2w = 1; e2n = 5;
    settle();
    chk("e2_stall", {31'd0, stall_id}, 32'd1);
    tick();
    e2w = 0; e3w = 1; e3n = 5; ed = 32'h40000000;
    settle();
    chk("e3_stall", {31'd0, stall_id}, 32'd0);
    chk("e3_a", a, 32'h40000000);
    chk("e3_wf", {31'd0, wf}, 32'd1);
    chk("e3_fd", {27'd0, fd}, 32'd9);
    chk("e3_cnt_stall", {16'd0, cnt_stall}, 32'd2);
    tick();
    chk("e3_cnt_issue", {16'd0, cnt_issue}, 32'd1);
    dec_valid = 0; dec_use_fs = 0; e3w = 0;

    // E3 beats write-back on the same register
    ww = 1; wn = 7; wd = 32'h11111111;
    e3w = 1; e3n = 7; ed = 32'h22222222;
    dec_ft = 7; dec_use_ft = 1;
    settle();
    chk("e3_over_wb", b, 32'h22222222);
    tick();
    ww = 0; e3w = 0;
    settle();
    chk("rf_b", b, 32'h11111111);
    tick();
    dec_use_ft = 0;

    // fdiv held under st_ds
    dec_valid = 1; dec_fc = FC_DIV; dec_wf = 1; dec_fd = 2;
    st_ds = 1;
    saved_stall = m_cnt_stall; saved_issue = m_cnt_issue;
    repeat (14) begin
      settle();
      chk("div_stall", {31'd0, stall_id}, 32'd1);
      chk("div_fc", {29'd0, fc}, {29'd0, FC_DIV});
      tick();
    end
    chk("div_frozen_stall", {16'd0, cnt_stall}, saved_stall);
    chk("div_frozen_issue", {16'd0, cnt_issue}, saved_issue);
    st_ds = 0;
    tick();
    chk("div_issue_once", {16'd0, cnt_issue}, saved_issue + 1);
    dec_valid = 0;

    // flush and memory stall
    flush = 1;
    settle();
    chk("flush_ein2", {31'd0, ein2}, 32'd0);
    tick();
    flush = 0;
    ein1 = 0; dec_valid = 1; dec_fc = FC_MUL; dec_wf = 1; dec_fd = 4;
    saved_issue = m_cnt_issue;
    repeat (3) begin
      settle();
      chk("mem_stall", {31'd0, stall_id}, 32'd1);
      chk("mem_fc", {29'd0, fc}, {29'd0, FC_MUL});
      chk("mem_wf", {31'd0, wf}, 32'd1);
      tick();
    end
    chk("mem_frozen_issue", {16'd0, cnt_issue}, saved_issue);
    ein1 = 1;
    dec_valid = 0;
    tick();

    // sustained hazard until the stall counter saturates
    dec_valid = 1; dec_fs = 1; dec_use_fs = 1; e1w = 1; e1n = 1;
    repeat (CNT_MAX + 5) @(posedge clk);
    #1;
    settle();
    chk("sat_stall", {16'd0, cnt_stall}, 32'h0000FFFF);
    tick();
    chk("sat_hold", {16'd0, cnt_stall}, 32'h0000FFFF);
    dec_valid = 0; e1w = 0;
    tick();

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
